// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    // Width of a word index (byte address without the two alignment bits)
    localparam int unsigned WORD_IDX_W = 30;

    // Default first fetch address and exception target
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fs_state_e;

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational redirect target: jump or taken conditional branch.
module next_pc_calc
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_branch,
    input  logic        i_jmp,
    input  logic        i_z,
    input  logic [25:0] i_target,
    input  logic [15:0] i_imm,
    output logic        o_taken_c,
    output logic [31:0] o_target_c
);

    logic [WORD_IDX_W-1:0] w_idx;
    logic [WORD_IDX_W-1:0] w_next_idx;
    logic                  w_unused_pc_lsb;

    assign w_idx           = i_pc[31:2];
    assign w_unused_pc_lsb = ^i_pc[1:0];

    // Jump keeps the top four index bits; branch is relative to the following word
    always_comb begin
        w_next_idx = w_idx + WORD_IDX_W'(1) + WORD_IDX_W'($signed(i_imm));
        if (i_jmp) begin
            w_next_idx = {w_idx[29:26], i_target};
        end
    end

    assign o_taken_c  = i_jmp | (i_branch & ~i_z);
    assign o_target_c = {w_next_idx, 2'b00};

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Optional feature: define EXC_VECTOR_EN to add the exc_valid redirect to EXC_VECTOR.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC
`ifdef EXC_VECTOR_EN
    ,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jmp,
    input  logic        ex_z,
    input  logic [25:0] ex_target,
    input  logic [15:0] ex_imm,
    input  logic [31:0] ex_pc
`ifdef EXC_VECTOR_EN
    ,
    input  logic        exc_valid
`endif
);

    fs_state_e   r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic        r_req_valid;
    logic [31:0] r_req_addr;
    logic        r_inst_valid;
    logic [31:0] r_inst_data;
    logic [31:0] r_inst_pc;

    logic        w_ex_taken;
    logic [31:0] w_ex_target;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_next_req;

    next_pc_calc u_next_pc_calc (
        .i_pc       (ex_pc),
        .i_branch   (ex_branch),
        .i_jmp      (ex_jmp),
        .i_z        (ex_z),
        .i_target   (ex_target),
        .i_imm      (ex_imm),
        .o_taken_c  (w_ex_taken),
        .o_target_c (w_ex_target)
    );

`ifdef EXC_VECTOR_EN
    assign w_redirect    = exc_valid | (ex_valid & w_ex_taken);
    assign w_redirect_pc = exc_valid ? EXC_VECTOR : w_ex_target;
`else
    assign w_redirect    = ex_valid & w_ex_taken;
    assign w_redirect_pc = w_ex_target;
`endif

    // Address of the next request issued on entry to REQ
    assign w_next_req = w_redirect ? w_redirect_pc : r_pc;

    // Fetch FSM with registered request and decode outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_req_addr   <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst_data  <= 32'd0;
            r_inst_pc    <= 32'd0;
        end else begin
            if (w_redirect) begin
                r_pc <= w_redirect_pc;
            end
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_REQ;
                    r_req_valid <= 1'b1;
                    r_req_addr  <= w_next_req;
                end
                ST_REQ: begin
                    // Address stays put until accepted; a redirect here kills the in-flight word
                    if (w_redirect) begin
                        r_kill <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        r_inst_data <= imem_resp_data;
                        r_inst_pc   <= r_req_addr;
                        if (r_kill || w_redirect) begin
                            r_kill      <= 1'b0;
                            r_state     <= ST_REQ;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= w_next_req;
                        end else begin
                            r_inst_valid <= 1'b1;
                            r_pc         <= r_pc + 32'd4;
                            r_state      <= ST_HOLD;
                        end
                    end else if (w_redirect) begin
                        r_kill <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Handshake or flush both release the output and refetch
                    if (inst_ready || w_redirect) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= ST_REQ;
                        r_req_valid  <= 1'b1;
                        r_req_addr   <= w_next_req;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;
    assign inst_valid     = r_inst_valid;
    assign inst_data      = r_inst_data;
    assign inst_pc        = r_inst_pc;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Owns the program counter and drives instruction fetch for the single-issue MIPS-style core. Issues one word request at a time to instruction memory over a valid/ready handshake and presents returned instructions to decode through a one-entry output register. Applies control-flow redirects resolved in execute using the core's next-PC rules: sequential, conditional branch and jump. Sits between the instruction memory port and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- EXC_VECTOR, 32'h0000_0080: exception target; only present with EXC_VECTOR_EN.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response for the oldest accepted request.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  decode output valid.
- inst_data  out  32  instruction to decode.
- inst_pc  out  32  address of inst_data.
- inst_ready  in  1  decode consumes the output this cycle.
- ex_valid  in  1  execute presents a resolved control instruction.
- ex_branch  in  1  conditional branch; taken when ex_z is 0.
- ex_jmp  in  1  jump; has priority over ex_branch.
- ex_z  in  1  zero flag of the branch comparison.
- ex_target  in  26  jump word index.
- ex_imm  in  16  signed branch word offset.
- ex_pc  in  32  address of the control instruction.
- exc_valid  in  1  exception redirect; only present with EXC_VECTOR_EN.

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: entered only from reset; moves to REQ on the first clock after rst_n deasserts.
- REQ: imem_req_valid=1 and imem_req_addr=pc_q. Hold the address until imem_req_ready. On acceptance go to WAIT.
- WAIT: on imem_resp_valid, load the output register with data and pc. If the kill flag is clear, set inst_valid, advance pc_q by 4 and go to HOLD. If kill is set, discard the word, clear kill and go to REQ.
- HOLD: inst_valid=1. When inst_ready is high, clear inst_valid and go to REQ. No new request is issued while the output is held.
- Redirect is taken when ex_valid is high and either ex_jmp is high or (ex_branch and not ex_z).
  - Arithmetic is on word indices p = ex_pc[31:2], 30 bits with modulo-2^30 wrap.
  - Jump: {p[29:26], ex_target}.
  - Branch: p + 1 + sign-extended ex_imm.
  - Address = index concatenated with 2'b00.
- On a taken redirect, pc_q is loaded with the target.
  - In REQ with the request not yet accepted: the address stays stable until accepted, then kill is set.
  - In WAIT: kill is set.
  - In HOLD: inst_valid is cleared and the state goes to REQ.
- Not-taken resolution or ex_valid with neither ex_branch nor ex_jmp: no effect.
- A redirect in the same cycle as imem_resp_valid discards that response. A redirect beats a normal pc increment.
- A redirect in the same cycle as an inst_ready handshake: the handshake completes, then the redirect applies.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, pc_q=RESET_PC, kill=0, state=IDLE.
- First request is asserted 1 cycle after reset release.
- Response latency is at least 1 cycle after request acceptance. At most one request is outstanding.
- inst_valid rises the cycle after imem_resp_valid.
- Best-case throughput is one instruction per 3 cycles.
- Redirect-to-request latency is 1 cycle from HOLD. From WAIT, the redirected request follows the discarded response by 1 cycle.
- Reset asserted mid-transaction returns all state to reset values immediately. A response arriving after reset is ignored because the state is IDLE or REQ.

## Configuration
- EXC_VECTOR_EN defined: adds the exc_valid port and the EXC_VECTOR parameter. exc_valid redirects to EXC_VECTOR with priority over ex_* and follows the same kill/flush rules.
- EXC_VECTOR_EN undefined: no port, no parameter, no logic.

## Structure
- Shared package holds:
  - State enum: IDLE, REQ, WAIT, HOLD.
  - RESET_PC and EXC_VECTOR defaults.
  - Word-index width constant (30).
- Sub-module next_pc_calc: combinational; takes pc, branch, jmp, z, target and imm; outputs the redirect-taken flag and the 32-bit target. Instantiated once for the ex_* path. The sequential +4 stays in the sequencer.

## Test plan
- Reset release, memory ready always, 1-cycle latency, inst_ready=1 → requests at 0x0, 0x4, 0x8; inst_pc matches each address.
- inst_ready held low for 5 cycles in HOLD → inst_valid and inst_data stable, imem_req_valid=0 throughout.
- ex_pc=0x0000_1000, ex_branch=1, ex_z=0, ex_imm=16'hFFFE while in WAIT → response dropped, next request at 0x0000_0FFC.
- ex_pc=0xF000_0010, ex_jmp=1, ex_target=26'h0000_040 during HOLD → inst_valid clears next cycle, request at 0xF000_0100.
- ex_branch=1, ex_z=1 → no redirect, sequential fetch continues.
- rst_n pulsed low while in WAIT, then a late imem_resp_valid → no inst_valid, next request at RESET_PC.
